// File: rtl/exe_pkg.sv
// Codes shared between decoder and execute stage, exception bit positions,
// and the divider state encoding.
package exe_pkg;

  localparam logic [2:0] ALU_SEL_NOP   = 3'd0;
  localparam logic [2:0] ALU_SEL_LOGIC = 3'd1;
  localparam logic [2:0] ALU_SEL_SHIFT = 3'd2;
  localparam logic [2:0] ALU_SEL_ARITH = 3'd3;
  localparam logic [2:0] ALU_SEL_MUL   = 3'd4;
  localparam logic [2:0] ALU_SEL_DIV   = 3'd5;

  localparam logic [7:0] ALU_OP_NOP   = 8'h00;
  localparam logic [7:0] ALU_OP_AND   = 8'h24;
  localparam logic [7:0] ALU_OP_OR    = 8'h25;
  localparam logic [7:0] ALU_OP_XOR   = 8'h26;
  localparam logic [7:0] ALU_OP_NOR   = 8'h27;
  localparam logic [7:0] ALU_OP_SLL   = 8'h7C;
  localparam logic [7:0] ALU_OP_SRL   = 8'h02;
  localparam logic [7:0] ALU_OP_SRA   = 8'h03;
  localparam logic [7:0] ALU_OP_ADD   = 8'h20;
  localparam logic [7:0] ALU_OP_ADDU  = 8'h21;
  localparam logic [7:0] ALU_OP_SUB   = 8'h22;
  localparam logic [7:0] ALU_OP_SUBU  = 8'h23;
  localparam logic [7:0] ALU_OP_SLT   = 8'h2A;
  localparam logic [7:0] ALU_OP_SLTU  = 8'h2B;
  localparam logic [7:0] ALU_OP_ADDI  = 8'h55;
  localparam logic [7:0] ALU_OP_ADDIU = 8'h56;
  localparam logic [7:0] ALU_OP_MULT  = 8'h18;
  localparam logic [7:0] ALU_OP_MULTU = 8'h19;
  localparam logic [7:0] ALU_OP_DIV   = 8'h1A;
  localparam logic [7:0] ALU_OP_DIVU  = 8'h1B;

  localparam int EXC_RI_BIT = 10;
  localparam int EXC_OV_BIT = 12;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/exe_divider.sv
// Restoring 32-bit divider: 1 start cycle, 32 BUSY cycles, results held for one DONE cycle.
// cancel_i returns to IDLE on the next edge; a zero divisor skips straight to DONE with 0/0.
module exe_divider
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        cancel_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        busy_o,
  output logic        ready_o
);

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        a_neg, b_neg, fits;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;

  assign a_neg   = signed_i & dividend_i[31];
  assign b_neg   = signed_i & divisor_i[31];
  assign a_mag   = a_neg ? -dividend_i : dividend_i;
  assign b_mag   = b_neg ? -divisor_i : divisor_i;
  // Partial remainder stays below the divisor, so a clear borrow means the trial fits.
  assign shifted = {rem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (cancel_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            cnt_d = '0;
            quo_d = '0;
            rem_d = '0;
            if (divisor_i == '0) begin
              state_d = DIV_DONE;
              dvd_d   = '0;
              dvs_d   = '0;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
            end else begin
              state_d = DIV_BUSY;
              dvd_d   = a_mag;
              dvs_d   = b_mag;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end
          end
        end
        DIV_BUSY: begin
          rem_d = fits ? diff[31:0] : shifted[31:0];
          quo_d = {quo_q[30:0], fits};
          dvd_d = {dvd_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DIV_DONE;
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign quotient_o  = qneg_q ? -quo_q : quo_q;
  assign remainder_o = rneg_q ? -rem_q : rem_q;
  assign busy_o      = (state_q == DIV_BUSY);
  assign ready_o     = (state_q == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU/MUL/HI-LO moves; DIV/DIVU via a multi-cycle divider that
// holds IF/ID/EXE through stall_req_o. Divider only built with EXE_DIV_EN, else DIV raises RI.
module exe_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [2:0]  alu_sel_i,
  input  logic [7:0]  alu_op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic        mt_hi_i,
  input  logic        mt_lo_i,
  input  logic        mf_hi_i,
  input  logic        mf_lo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        rmem_i,
  input  logic        wmem_i,
  input  logic [31:0] mem_io_addr_i,
  input  logic [31:0] exception_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        rmem_o,
  output logic        wmem_o,
  output logic [31:0] mem_io_addr_o,
  output logic [31:0] exception_o,
  output logic [31:0] pc_o,
  output logic        in_delayslot_o,
  output logic        stall_req_o
);

  logic        is_div, is_mul, ov, trap;
  logic [31:0] sum, dif, logic_res, shift_res, arith_res, exc_local;
  logic [63:0] mul_a, mul_b, product;
  logic        div_done, div_ri;
  logic [31:0] div_quo, div_rem;

  assign is_div = (alu_sel_i == ALU_SEL_DIV) &&
                  ((alu_op_i == ALU_OP_DIV) || (alu_op_i == ALU_OP_DIVU));
  assign is_mul = (alu_sel_i == ALU_SEL_MUL) &&
                  ((alu_op_i == ALU_OP_MULT) || (alu_op_i == ALU_OP_MULTU));

  assign sum = reg1_i + reg2_i;
  assign dif = reg1_i - reg2_i;

  always_comb begin
    logic_res = '0;
    case (alu_op_i)
      ALU_OP_AND: logic_res = reg1_i & reg2_i;
      ALU_OP_OR:  logic_res = reg1_i | reg2_i;
      ALU_OP_XOR: logic_res = reg1_i ^ reg2_i;
      ALU_OP_NOR: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (alu_op_i)
      ALU_OP_SLL: shift_res = reg2_i << reg1_i[4:0];
      ALU_OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
      ALU_OP_SRA: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    ov        = 1'b0;
    case (alu_op_i)
      ALU_OP_ADD, ALU_OP_ADDI: begin
        arith_res = sum;
        ov        = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
      end
      ALU_OP_ADDU, ALU_OP_ADDIU: arith_res = sum;
      ALU_OP_SUB: begin
        arith_res = dif;
        ov        = (reg1_i[31] != reg2_i[31]) && (dif[31] != reg1_i[31]);
      end
      ALU_OP_SUBU: arith_res = dif;
      ALU_OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      ALU_OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
      default:     arith_res = '0;
    endcase
  end

  assign trap = (alu_sel_i == ALU_SEL_ARITH) && ov;

  // Sign- or zero-extend to 64 bits so one truncated multiply serves MULT and MULTU.
  assign mul_a   = (alu_op_i == ALU_OP_MULT) ? {{32{reg1_i[31]}}, reg1_i} : {32'b0, reg1_i};
  assign mul_b   = (alu_op_i == ALU_OP_MULT) ? {{32{reg2_i[31]}}, reg2_i} : {32'b0, reg2_i};
  assign product = mul_a * mul_b;

`ifdef EXE_DIV_EN
  logic div_start, div_busy, div_ready;

  assign div_start = is_div && (exception_i == '0) && !flush_i && !div_busy && !div_ready;

  exe_divider u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .signed_i    (alu_op_i == ALU_OP_DIV),
    .cancel_i    (flush_i),
    .dividend_i  (reg1_i),
    .divisor_i   (reg2_i),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .busy_o      (div_busy),
    .ready_o     (div_ready)
  );

  assign stall_req_o = rst_n && !flush_i && (div_start || div_busy);
  assign div_done    = div_ready;
  assign div_ri      = 1'b0;
`else
  logic unused_clk;

  assign unused_clk  = clk;
  assign stall_req_o = 1'b0;
  assign div_done    = 1'b0;
  assign div_quo     = '0;
  assign div_rem     = '0;
  assign div_ri      = is_div;
`endif

  always_comb begin
    wdata_o = '0;
    case (alu_sel_i)
      ALU_SEL_LOGIC: wdata_o = logic_res;
      ALU_SEL_SHIFT: wdata_o = shift_res;
      ALU_SEL_ARITH: wdata_o = arith_res;
      default:       wdata_o = '0;
    endcase
    if (mf_hi_i)      wdata_o = hi_i;
    else if (mf_lo_i) wdata_o = lo_i;
  end

  always_comb begin
    whilo_o = 1'b0;
    hi_o    = hi_i;
    lo_o    = lo_i;
    if (mt_hi_i) begin
      whilo_o = 1'b1;
      hi_o    = reg1_i;
    end else if (mt_lo_i) begin
      whilo_o = 1'b1;
      lo_o    = reg1_i;
    end else if (is_mul) begin
      whilo_o = 1'b1;
      hi_o    = product[63:32];
      lo_o    = product[31:0];
    end else if (div_done) begin
      whilo_o = 1'b1;
      hi_o    = div_rem;
      lo_o    = div_quo;
    end
    if (flush_i || !rst_n) whilo_o = 1'b0;
  end

  always_comb begin
    exc_local             = '0;
    exc_local[EXC_OV_BIT] = trap;
    exc_local[EXC_RI_BIT] = div_ri;
  end

  assign wreg_o         = wreg_i && !trap && !is_div;
  assign wd_o           = wd_i;
  assign exception_o    = exception_i | exc_local;
  assign rmem_o         = rmem_i;
  assign wmem_o         = wmem_i;
  assign mem_io_addr_o  = mem_io_addr_i;
  assign pc_o           = pc_i;
  assign in_delayslot_o = in_delayslot_i;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model; divider checks
// are selected by EXE_DIV_EN to match the build.
`timescale 1ns/1ps
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [2:0]  alu_sel_i;
  logic [7:0]  alu_op_i;
  logic [31:0] reg1_i, reg2_i;
  logic        wreg_i;
  logic [4:0]  wd_i;
  logic        mt_hi_i, mt_lo_i, mf_hi_i, mf_lo_i;
  logic [31:0] hi_i, lo_i;
  logic        rmem_i, wmem_i;
  logic [31:0] mem_io_addr_i, exception_i, pc_i;
  logic        in_delayslot_i;
  logic        wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        rmem_o, wmem_o;
  logic [31:0] mem_io_addr_o, exception_o, pc_o;
  logic        in_delayslot_o;
  logic        stall_req_o;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .alu_sel_i(alu_sel_i), .alu_op_i(alu_op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wreg_i(wreg_i), .wd_i(wd_i),
    .mt_hi_i(mt_hi_i), .mt_lo_i(mt_lo_i), .mf_hi_i(mf_hi_i), .mf_lo_i(mf_lo_i),
    .hi_i(hi_i), .lo_i(lo_i), .rmem_i(rmem_i), .wmem_i(wmem_i),
    .mem_io_addr_i(mem_io_addr_i), .exception_i(exception_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i),
    .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .rmem_o(rmem_o), .wmem_o(wmem_o),
    .mem_io_addr_o(mem_io_addr_o), .exception_o(exception_o), .pc_o(pc_o),
    .in_delayslot_o(in_delayslot_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] wdata;
    logic        ov;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] op;
  } opc_t;

  localparam int NOPS = 18;
  opc_t ops [NOPS];

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 input logic mth, input logic mtl, input logic mfh, input logic mfl);
    exp_t e;
    longint sa, sb, s;
    longint unsigned u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.wdata = '0; e.ov = 1'b0; e.whilo = 1'b0; e.hi = hi_in; e.lo = lo_in;
    case (op)
      ALU_OP_ADD, ALU_OP_ADDI: begin
        s = sa + sb; e.wdata = s[31:0]; e.ov = (s != longint'($signed(s[31:0])));
      end
      ALU_OP_ADDU, ALU_OP_ADDIU: e.wdata = a + b;
      ALU_OP_SUB: begin
        s = sa - sb; e.wdata = s[31:0]; e.ov = (s != longint'($signed(s[31:0])));
      end
      ALU_OP_SUBU: e.wdata = a - b;
      ALU_OP_SLT:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: e.wdata = (a < b) ? 32'd1 : 32'd0;
      ALU_OP_AND:  e.wdata = a & b;
      ALU_OP_OR:   e.wdata = a | b;
      ALU_OP_XOR:  e.wdata = a ^ b;
      ALU_OP_NOR:  e.wdata = ~(a | b);
      ALU_OP_SLL:  e.wdata = b << a[4:0];
      ALU_OP_SRL:  e.wdata = b >> a[4:0];
      ALU_OP_SRA: begin s = sb >>> a[4:0]; e.wdata = s[31:0]; end
      ALU_OP_MULT: begin
        s = sa * sb; e.whilo = 1'b1; e.hi = s[63:32]; e.lo = s[31:0];
      end
      ALU_OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b}; e.whilo = 1'b1; e.hi = u[63:32]; e.lo = u[31:0];
      end
      default: e.wdata = '0;
    endcase
    if (mfh)      e.wdata = hi_in;
    else if (mfl) e.wdata = lo_in;
    if (mth) begin e.whilo = 1'b1; e.hi = a; e.lo = lo_in; end
    else if (mtl) begin e.whilo = 1'b1; e.hi = hi_in; e.lo = a; end
    return e;
  endfunction

  // Returns {remainder, quotient}; C-style truncating division on wide signed integers.
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else begin x = longint'({32'b0, a}); y = longint'({32'b0, b}); end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rnd32();
    logic [31:0] corner [5];
    corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic set_nop();
    alu_sel_i = ALU_SEL_NOP; alu_op_i = ALU_OP_NOP;
    mt_hi_i = 1'b0; mt_lo_i = 1'b0; mf_hi_i = 1'b0; mf_lo_i = 1'b0;
    exception_i = '0; wreg_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic apply_comb(input string tag, input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic mth, input logic mtl, input logic mfh, input logic mfl);
    exp_t e;
    logic [31:0] exc_exp;
    @(negedge clk);
    alu_sel_i = sel; alu_op_i = op; reg1_i = a; reg2_i = b;
    mt_hi_i = mth; mt_lo_i = mtl; mf_hi_i = mfh; mf_lo_i = mfl;
    hi_i = $urandom; lo_i = $urandom; wreg_i = 1'b1; wd_i = 5'($urandom);
    rmem_i = 1'($urandom); wmem_i = 1'($urandom); in_delayslot_i = 1'($urandom);
    mem_io_addr_i = $urandom; pc_i = $urandom;
    exception_i = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
    #1;
    e = model(op, a, b, hi_i, lo_i, mth, mtl, mfh, mfl);
    exc_exp = exception_i;
    if (e.ov) exc_exp[EXC_OV_BIT] = 1'b1;
    check({tag, "_wdata"}, wdata_o, e.wdata);
    check({tag, "_wreg"}, wreg_o, !e.ov);
    check({tag, "_exc"}, exception_o, exc_exp);
    check({tag, "_whilo"}, whilo_o, e.whilo);
    check({tag, "_hilo"}, {hi_o, lo_o}, {e.hi, e.lo});
    check({tag, "_stall"}, stall_req_o, 1'b0);
    check({tag, "_pass_a"}, {mem_io_addr_o, pc_o}, {mem_io_addr_i, pc_i});
    check({tag, "_pass_b"}, {rmem_o, wmem_o, in_delayslot_o, wd_o},
          {rmem_i, wmem_i, in_delayslot_i, wd_i});
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int cycles;
    @(negedge clk);
    set_nop();
    alu_sel_i = ALU_SEL_DIV; alu_op_i = op; reg1_i = a; reg2_i = b;
    #1;
    cycles = 0;
    while (stall_req_o && cycles < 100) begin
      @(negedge clk); #1;
      cycles++;
    end
    check({tag, "_stall_cycles"}, 64'(cycles), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, "_whilo"}, whilo_o, 1'b1);
    check({tag, "_lo"}, lo_o, eq);
    check({tag, "_hi"}, hi_o, er);
    check({tag, "_wreg"}, wreg_o, 1'b0);
    set_nop();
    @(negedge clk); #1;
    check({tag, "_idle"}, {stall_req_o, whilo_o}, 2'b00);
  endtask

  task automatic quiet_window(input string tag);
    int busy_seen;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (stall_req_o || whilo_o) busy_seen++;
    end
    check({tag, "_quiet"}, 64'(busy_seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rq;
    logic [31:0] a, b;
    logic [7:0]  dop;
    int          k, f;

    ops = '{{ALU_SEL_ARITH, ALU_OP_ADD}, {ALU_SEL_ARITH, ALU_OP_ADDU}, {ALU_SEL_ARITH, ALU_OP_SUB},
            {ALU_SEL_ARITH, ALU_OP_SUBU}, {ALU_SEL_ARITH, ALU_OP_ADDI}, {ALU_SEL_ARITH, ALU_OP_ADDIU},
            {ALU_SEL_ARITH, ALU_OP_SLT}, {ALU_SEL_ARITH, ALU_OP_SLTU}, {ALU_SEL_LOGIC, ALU_OP_AND},
            {ALU_SEL_LOGIC, ALU_OP_OR}, {ALU_SEL_LOGIC, ALU_OP_XOR}, {ALU_SEL_LOGIC, ALU_OP_NOR},
            {ALU_SEL_SHIFT, ALU_OP_SLL}, {ALU_SEL_SHIFT, ALU_OP_SRL}, {ALU_SEL_SHIFT, ALU_OP_SRA},
            {ALU_SEL_MUL, ALU_OP_MULT}, {ALU_SEL_MUL, ALU_OP_MULTU}, {ALU_SEL_NOP, ALU_OP_NOP}};

    rst_n = 1'b1;
    set_nop();
    reg1_i = '0; reg2_i = '0; wd_i = '0; hi_i = '0; lo_i = '0;
    rmem_i = 1'b0; wmem_i = 1'b0; mem_io_addr_i = '0; pc_i = '0; in_delayslot_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 alu_sel_i = ALU_SEL_MUL; alu_op_i = ALU_OP_MULT; reg1_i = 32'd3; reg2_i = 32'd4;
    #1 check("rst_whilo", whilo_o, 1'b0);
    alu_sel_i = ALU_SEL_DIV; alu_op_i = ALU_OP_DIV; reg1_i = 32'd20; reg2_i = 32'd5;
    #1 check("rst_stall", stall_req_o, 1'b0);
    set_nop();
    #13 rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst", {stall_req_o, whilo_o, wdata_o}, 34'd0);

    apply_comb("add_ovf", ALU_SEL_ARITH, ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0);
    check("add_ovf_bit", exception_o[EXC_OV_BIT], 1'b1);
    check("add_ovf_wreg", wreg_o, 1'b0);
    apply_comb("addu_wrap", ALU_SEL_ARITH, ALU_OP_ADDU, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0);
    check("addu_wrap_val", {wreg_o, wdata_o}, {1'b1, 32'h8000_0000});
    apply_comb("sub_ovf", ALU_SEL_ARITH, ALU_OP_SUB, 32'h8000_0000, 32'h1, 0, 0, 0, 0);
    apply_comb("mult_m1x2", ALU_SEL_MUL, ALU_OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0);
    check("mult_m1x2_val", {whilo_o, stall_req_o, hi_o, lo_o},
          {1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});

    for (int i = 0; i < 240; i++) begin
      k = $urandom_range(0, NOPS - 1);
      apply_comb($sformatf("rnd_op%02h", ops[k].op), ops[k].sel, ops[k].op, rnd32(), rnd32(), 0, 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      f = $urandom_range(0, 3);
      apply_comb($sformatf("move%0d", f), ALU_SEL_NOP, ALU_OP_NOP, $urandom, $urandom,
                 f == 0, f == 1, f == 2, f == 3);
    end
    set_nop();

`ifdef EXE_DIV_EN
    run_div("div_m7_2", ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_by0", ALU_OP_DIVU, 32'd100, 32'd0, 32'd0, 32'd0);
    run_div("div_minneg", ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dop = ($urandom_range(0, 1) == 0) ? ALU_OP_DIV : ALU_OP_DIVU;
      a = rnd32();
      b = (i == 3) ? 32'd0 : (rnd32() >> $urandom_range(0, 31));
      rq = div_ref(dop == ALU_OP_DIV, a, b);
      run_div($sformatf("rnd_div%0d", i), dop, a, b, rq[31:0], rq[63:32]);
    end

    @(negedge clk);
    alu_sel_i = ALU_SEL_DIV; alu_op_i = ALU_OP_DIV; reg1_i = 32'd20; reg2_i = 32'd3;
    exception_i = 32'h0000_0004; wreg_i = 1'b1;
    #1;
    check("div_exc_now", {stall_req_o, whilo_o, wreg_o}, 3'b000);
    check("div_exc_pass", exception_o, 32'h0000_0004);
    @(negedge clk); #1;
    check("div_exc_nostart", stall_req_o, 1'b0);
    set_nop();

    @(negedge clk);
    alu_sel_i = ALU_SEL_DIV; alu_op_i = ALU_OP_DIVU; reg1_i = 32'hFFFF_FFF0; reg2_i = 32'd7;
    #1 check("fl_start", stall_req_o, 1'b1);
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    #1 check("fl_now", {stall_req_o, whilo_o}, 2'b00);
    @(posedge clk); #1;
    set_nop();
    quiet_window("fl");
    run_div("fl_next", ALU_OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

    @(negedge clk);
    alu_sel_i = ALU_SEL_DIV; alu_op_i = ALU_OP_DIV; reg1_i = 32'hFFFF_FC18; reg2_i = 32'd3;
    repeat (21) @(negedge clk);
    #1 check("rs_busy", stall_req_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rs_now", {stall_req_o, whilo_o}, 2'b00);
    set_nop();
    @(negedge clk) rst_n = 1'b1;
    quiet_window("rs");
    run_div("rs_next", ALU_OP_DIVU, 32'd10, 32'd4, 32'd2, 32'd2);
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_sel_i = ALU_SEL_DIV; alu_op_i = (i % 2 == 0) ? ALU_OP_DIV : ALU_OP_DIVU;
      reg1_i = $urandom; reg2_i = (i == 1) ? 32'd0 : 32'($urandom); exception_i = '0; wreg_i = 1'b1;
      #1;
      check($sformatf("nodiv_ri%0d", i), exception_o, 32'd1 << EXC_RI_BIT);
      check($sformatf("nodiv_hs%0d", i), {stall_req_o, whilo_o, wreg_o}, 3'b000);
      @(negedge clk); #1;
      check($sformatf("nodiv_st%0d", i), {stall_req_o, whilo_o}, 2'b00);
    end
    set_nop();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port flush_i  in  1  kills current operation, including an in-flight divide.
REQ-004 SHALL have ports alu_sel_i  in  3  and alu_op_i  in  8  carrying operation class and code from the ID/EXE register.
REQ-005 SHALL have ports reg1_i, reg2_i  in  32  operands; wreg_i  in  1  and wd_i  in  5  destination register.
REQ-006 SHALL have ports mt_hi_i, mt_lo_i, mf_hi_i, mf_lo_i  in  1  HI/LO moves; hi_i, lo_i  in  32  forwarded HI/LO.
REQ-007 SHALL have ports rmem_i, wmem_i  in  1; mem_io_addr_i, exception_i, pc_i  in  32; in_delayslot_i  in  1.
REQ-008 SHALL have ports wreg_o  out  1, wd_o  out  5, wdata_o  out  32, whilo_o  out  1, hi_o  out  32, lo_o  out  32.
REQ-009 SHALL have ports rmem_o, wmem_o  out  1; mem_io_addr_o, exception_o, pc_o  out  32; in_delayslot_o  out  1.
REQ-010 SHALL have port stall_req_o  out  1  which holds IF/ID/EXE while a divide is incomplete.

Function
REQ-011 Non-divide ops SHALL be combinational: results valid in the same cycle as the inputs.
REQ-012 ADD/ADDI/SUB signed overflow SHALL set exception_o[EXC_OV_BIT] and force wreg_o=0; ADDU/SUBU SHALL never trap.
REQ-013 MULT/MULTU SHALL form a 64-bit product with hi_o=product[63:32], lo_o=product[31:0] and whilo_o=1.
REQ-014 mf_hi_i/mf_lo_i SHALL give wdata_o=hi_i/lo_i; mt_hi_i SHALL give whilo_o=1, hi_o=reg1_i, lo_o=lo_i; mt_lo_i is the mirror case.
REQ-015 rmem, wmem, mem_io_addr, exception (OR'd with local bits), pc and in_delayslot SHALL pass through unchanged otherwise.
REQ-016 Divider FSM states SHALL be IDLE, BUSY and DONE, with a 5-bit iteration counter.
REQ-017 IDLE->BUSY SHALL occur on DIV/DIVU with exception_i==0, flush_i==0 and a nonzero divisor; divisor==0 SHALL go IDLE->DONE with hi=lo=0.
REQ-018 BUSY SHALL retire one quotient bit per cycle (restoring division), 32 cycles, counter 0..31, then go BUSY->DONE.
REQ-019 DONE SHALL present lo_o=quotient, hi_o=remainder, whilo_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 stall_req_o SHALL be 1 combinationally in the IDLE cycle that starts a divide and throughout BUSY, 0 in DONE; a nonzero-divisor divide stalls exactly 33 cycles.
REQ-021 Signed divide SHALL use magnitudes; quotient negated if operand signs differ, remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0, no exception.
REQ-022 flush_i in any state SHALL force stall_req_o=0 and whilo_o=0 in the same cycle and the FSM to IDLE on the next edge.
REQ-023 A divide with exception_i!=0 SHALL not start; whilo_o=0 and wreg_o=0.

Reset
REQ-024 rst_n low SHALL asynchronously set the FSM to IDLE and clear the counter and the dividend, divisor, quotient and remainder registers to 0.
REQ-025 While rst_n is low, stall_req_o and whilo_o SHALL be 0; reset mid-divide SHALL discard the operation.

Configuration
REQ-026 With EXE_DIV_EN defined, the divider SHALL be present as specified.
REQ-027 Without EXE_DIV_EN, no divider state SHALL exist, stall_req_o SHALL be tied 0, and DIV/DIVU SHALL set exception_o[EXC_RI_BIT] with whilo_o=0.

Structure
REQ-028 Package exe_pkg SHALL hold the ALU_SEL_* and ALU_OP_* codes shared with the decoder, EXC_OV_BIT/EXC_RI_BIT, and the div_state_t enum.
REQ-029 The divider SHALL be sub-module exe_divider, with start, signed, cancel, divisor and dividend inputs and quotient, remainder, busy and ready outputs.

Verification
REQ-030 ADD 0x7FFFFFFF+1 -> exception_o OV bit set, wreg_o=0; ADDU same operands -> wdata_o=0x80000000, wreg_o=1.
REQ-031 MULT 0xFFFFFFFF*2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, whilo_o=1, no stall.
REQ-032 DIV -7/2 -> stall_req_o high 33 cycles, then one cycle lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1.
REQ-033 DIVU 100/0 -> one stall cycle, DONE with hi_o=lo_o=0; DIV 0x80000000/-1 -> lo_o=0x80000000, hi_o=0.
REQ-034 flush_i pulsed at BUSY cycle 10 -> stall_req_o=0 that cycle, no whilo_o pulse, next DIVU 9/3 completes normally with lo_o=3.
REQ-035 rst_n low at BUSY cycle 20 -> FSM IDLE, stall_req_o=0 immediately; after release, DIVU 10/4 -> lo_o=2, hi_o=2.
